// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pooling path: pixel width, 2x2 window
// slot indices and a width helper for counters.
package cnn_pkg;

    // Default pixel width, shared with the max-pooling stage.
    localparam int DATA_SIZE = 8;

    // Slot order of a 2x2 pooling window.
    localparam int WIN_TL  = 0;
    localparam int WIN_TR  = 1;
    localparam int WIN_BL  = 2;
    localparam int WIN_BR  = 3;
    localparam int NUM_WIN = 4;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int res;
        res = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One-row line buffer: synchronous write, two combinational read ports
// returning the pixel at rd_addr and at rd_addr-1 (the left neighbour).
module pool_line_buffer #(
    parameter int DATA_SIZE = 8,
    parameter int IMG_WIDTH = 8,
    parameter int AW        = 3
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [DATA_SIZE-1:0] rd_data_cur,
    output logic [DATA_SIZE-1:0] rd_data_prev
);

    logic [DATA_SIZE-1:0] mem [0:IMG_WIDTH-1];
    logic [AW-1:0]        rd_addr_prev;

    // Storage is not reset: every entry is rewritten in the even row before
    // it is read in the following odd row.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Left-neighbour address; clamped at 0 so the read never leaves the array
    // (only odd addresses are actually consumed).
    always_comb begin
        rd_addr_prev = (rd_addr == '0) ? '0 : rd_addr - AW'(1);
    end

    assign rd_data_cur  = mem[rd_addr];
    assign rd_data_prev = mem[rd_addr_prev];

endmodule

// File: rtl/pool_window_gen.sv
// Turns a raster pixel stream into non-overlapping 2x2 pooling windows.
// Even rows are buffered; in odd rows, each odd column completes a window
// which is presented one cycle later with a single-cycle valid pulse.
module pool_window_gen
    import cnn_pkg::*;
#(
    parameter int DATA_SIZE  = cnn_pkg::DATA_SIZE,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic [DATA_SIZE-1:0] win0,
    output logic [DATA_SIZE-1:0] win1,
    output logic [DATA_SIZE-1:0] win2,
    output logic [DATA_SIZE-1:0] win3,
    output logic                 win_valid,
    output logic                 frame_done
);

    localparam int CW = clog2(IMG_WIDTH);
    localparam int RW = clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]        col_cnt_q, col_cnt_d;
    logic [RW-1:0]        row_cnt_q, row_cnt_d;
    logic [DATA_SIZE-1:0] held_q, held_d;
    logic [DATA_SIZE-1:0] win_q [NUM_WIN];
    logic [DATA_SIZE-1:0] win_d [NUM_WIN];
    logic                 win_valid_q, win_valid_d;
    logic                 frame_done_q, frame_done_d;

    logic                 accept;
    logic                 lb_wr_en;
    logic [DATA_SIZE-1:0] lb_cur, lb_prev;

    assign accept   = in_valid && !clear;
    assign lb_wr_en = accept && !row_cnt_q[0];

    pool_line_buffer #(
        .DATA_SIZE (DATA_SIZE),
        .IMG_WIDTH (IMG_WIDTH),
        .AW        (CW)
    ) u_line_buffer (
        .clk          (clk),
        .wr_en        (lb_wr_en),
        .wr_addr      (col_cnt_q),
        .wr_data      (in_data),
        .rd_addr      (col_cnt_q),
        .rd_data_cur  (lb_cur),
        .rd_data_prev (lb_prev)
    );

    // Next-state: raster counters, held bottom-left pixel and window capture.
    always_comb begin
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        held_d       = held_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        for (int i = 0; i < NUM_WIN; i++) begin
            win_d[i] = win_q[i];
        end

        if (clear) begin
            col_cnt_d = '0;
            row_cnt_d = '0;
        end else if (in_valid) begin
            if (row_cnt_q[0]) begin
                if (!col_cnt_q[0]) begin
                    held_d = in_data;
                end else begin
                    win_d[WIN_TL] = lb_prev;
                    win_d[WIN_TR] = lb_cur;
                    win_d[WIN_BL] = held_q;
                    win_d[WIN_BR] = in_data;
                    win_valid_d   = 1'b1;
                    frame_done_d  = (row_cnt_q == ROW_LAST) && (col_cnt_q == COL_LAST);
                end
            end

            if (col_cnt_q == COL_LAST) begin
                col_cnt_d = '0;
                row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + RW'(1);
            end else begin
                col_cnt_d = col_cnt_q + CW'(1);
            end
        end
    end

    // Control registers: counters, held pixel and the output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            held_q       <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            held_q       <= held_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // One register per window slot; they hold between windows.
    generate
        for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_win
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    win_q[gi] <= '0;
                end else begin
                    win_q[gi] <= win_d[gi];
                end
            end
        end
    endgenerate

    assign win0       = win_q[WIN_TL];
    assign win1       = win_q[WIN_TR];
    assign win2       = win_q[WIN_BL];
    assign win3       = win_q[WIN_BR];
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen on a 4x4 frame of 8-bit pixels.
module tb_pool_window_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] win0, win1, win2, win3;
    logic       win_valid, frame_done;

    int checks = 0;
    int errors = 0;
    int nwin   = 0;
    int ndone  = 0;

    // Hand-computed windows of a 4x4 frame with pixels 0..15 (raster order).
    int tbl [4][4] = '{'{0, 1, 4, 5}, '{2, 3, 6, 7}, '{8, 9, 12, 13}, '{10, 11, 14, 15}};

    pool_window_gen #(
        .DATA_SIZE  (8),
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .win0       (win0),
        .win1       (win1),
        .win2       (win2),
        .win3       (win3),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic c, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        clear    = c;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        $display("step valid=%0b clear=%0b data=%02h -> win_valid=%0b frame_done=%0b win=%02h %02h %02h %02h",
                 v, c, d, win_valid, frame_done, win0, win1, win2, win3);
    endtask

    task automatic check_none(input string tag);
        chk({tag, "_valid"}, 32'(win_valid), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
    endtask

    task automatic check_win(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic done);
        chk({tag, "_valid"}, 32'(win_valid), 32'd1);
        chk({tag, "_w0"}, 32'(win0), 32'(e0));
        chk({tag, "_w1"}, 32'(win1), 32'(e1));
        chk({tag, "_w2"}, 32'(win2), 32'(e2));
        chk({tag, "_w3"}, 32'(win3), 32'(e3));
        chk({tag, "_done"}, 32'(frame_done), 32'(done));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_w0"}, 32'(win0), 32'd0);
        chk({tag, "_w1"}, 32'(win1), 32'd0);
        chk({tag, "_w2"}, 32'(win2), 32'd0);
        chk({tag, "_w3"}, 32'(win3), 32'd0);
        check_none(tag);
    endtask

    // Send the first npix pixels of a frame base+0..base+15 with optional
    // random idle gaps; every cycle is checked against the hand table.
    task automatic run_frame(input string tag, input int base, input int max_gap, input int npix);
        int gaps;
        int idx;
        for (int i = 0; i < npix; i++) begin
            gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gaps; g++) begin
                step(1'b0, 1'b0, 8'hA5);
                check_none({tag, "_gap"});
            end
            step(1'b1, 1'b0, 8'(base + i));
            if ((((i / 4) % 2) == 1) && ((i % 2) == 1)) begin
                idx = (i / 8) * 2 + (i % 4) / 2;
                check_win({tag, "_win"}, 8'(base + tbl[idx][0]), 8'(base + tbl[idx][1]),
                          8'(base + tbl[idx][2]), 8'(base + tbl[idx][3]), (i == 15));
            end else begin
                check_none({tag, "_pix"});
            end
            if (win_valid) nwin++;
            if (frame_done) ndone++;
        end
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame, in_valid held high.
        nwin = 0; ndone = 0;
        run_frame("basic", 0, 0, 16);
        chk("basic_nwin", 32'(nwin), 32'd4);
        chk("basic_ndone", 32'(ndone), 32'd1);

        // Same frame with random idle gaps.
        run_frame("gaps", 0, 3, 16);

        // Signed pass-through in the top-left block.
        step(1'b1, 1'b0, 8'h80); check_none("signed_p0");
        step(1'b1, 1'b0, 8'hFF); check_none("signed_p1");
        step(1'b1, 1'b0, 8'h01); check_none("signed_p2");
        step(1'b1, 1'b0, 8'h02); check_none("signed_p3");
        step(1'b1, 1'b0, 8'h7F); check_none("signed_p4");
        step(1'b1, 1'b0, 8'h00);
        check_win("signed", 8'h80, 8'hFF, 8'h7F, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'hEE); check_none("signed_clear");

        // Asynchronous reset after pixel 6, then a fresh frame.
        run_frame("prerst", 0, 0, 7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("postrst", 100, 0, 16);

        // Synchronous clear after pixel 9 (clear-cycle data must be ignored).
        run_frame("preclr", 0, 0, 10);
        step(1'b1, 1'b1, 8'hEE);
        check_none("clear");
        run_frame("postclr", 100, 0, 16);

        // Two frames back to back.
        nwin = 0; ndone = 0;
        run_frame("b2b_a", 0, 0, 16);
        run_frame("b2b_b", 200, 0, 16);
        chk("b2b_nwin", 32'(nwin), 32'd8);
        chk("b2b_ndone", 32'(ndone), 32'd2);

        // Idle cycles after the frame produce nothing.
        step(1'b0, 1'b0, 8'h55); check_none("idle0");
        step(1'b0, 1'b0, 8'h55); check_none("idle1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
